// File: rtl/fifo_sync_lvl.sv
// Synchronous valid/ready FIFO with first-word-fall-through output.
// Exposes fill level, almost-full/empty flags, synchronous flush and a peak-occupancy monitor.
module fifo_sync_lvl #(
  parameter int WIDTH_P  = 8,
  parameter int DEPTH_P  = 16,
  parameter int AFULL_P  = DEPTH_P - 2,
  parameter int AEMPTY_P = 2,
  parameter int PW_P     = $clog2(DEPTH_P),
  parameter int CW_P     = $clog2(DEPTH_P + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush_i,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic [WIDTH_P-1:0] data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [CW_P-1:0]    level_o,
  output logic               almost_full_o,
  output logic               almost_empty_o,
  output logic [CW_P-1:0]    peak_o
);

  localparam logic [PW_P-1:0] LAST_PTR = PW_P'(DEPTH_P - 1);
  localparam logic [CW_P-1:0] DEPTH_C  = CW_P'(DEPTH_P);
  localparam logic [CW_P-1:0] AFULL_C  = CW_P'(AFULL_P);
  localparam logic [CW_P-1:0] AEMPTY_C = CW_P'(AEMPTY_P);

  logic [WIDTH_P-1:0] mem [DEPTH_P];
  logic [PW_P-1:0]    wr_ptr;
  logic [PW_P-1:0]    rd_ptr;
  logic [CW_P-1:0]    next_level;
  logic               wr;
  logic               rd;

  assign wr     = valid_i & ready_o;
  assign rd     = valid_o & ready_i;
  assign data_o = mem[rd_ptr];

  always_comb begin
    next_level = level_o;
    if (wr && !rd)
      next_level = level_o + CW_P'(1);
    else if (rd && !wr)
      next_level = level_o - CW_P'(1);
  end

  // Storage is not reset; writes landing in a flush cycle are dropped.
  always_ff @(posedge clk) begin
    if (wr && !flush_i)
      mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      peak_o         <= '0;
      ready_o        <= 1'b1;
      valid_o        <= 1'b0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
    end else if (flush_i) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      level_o        <= '0;
      peak_o         <= '0;
      ready_o        <= 1'b1;
      valid_o        <= 1'b0;
      almost_full_o  <= 1'b0;
      almost_empty_o <= 1'b1;
    end else begin
      // Explicit wrap so non-power-of-two depths use every entry.
      if (wr)
        wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PW_P'(1);
      if (rd)
        rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PW_P'(1);
      level_o        <= next_level;
      ready_o        <= (next_level != DEPTH_C);
      valid_o        <= (next_level != '0);
      almost_full_o  <= (next_level >= AFULL_C);
      almost_empty_o <= (next_level <= AEMPTY_C);
      if (next_level > peak_o)
        peak_o <= next_level;
    end
  end

endmodule

// File: tb/tb_fifo_sync_lvl.sv
// Directed bench for fifo_sync_lvl (DEPTH 5): status checks against hand-computed values,
// data order checked by a scoreboard queue popped by an independent monitor.
module tb_fifo_sync_lvl;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush_i;
  logic [7:0] data_i;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic [2:0] level_o;
  logic       almost_full_o;
  logic       almost_empty_o;
  logic [2:0] peak_o;

  int checks = 0;
  int passes = 0;
  int model_level = 0;
  logic [7:0] expq [$];

  fifo_sync_lvl #(.WIDTH_P(8), .DEPTH_P(5), .AFULL_P(4), .AEMPTY_P(1)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .level_o(level_o), .almost_full_o(almost_full_o), .almost_empty_o(almost_empty_o),
    .peak_o(peak_o)
  );

  always #5 clk = ~clk;

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic checkOutput(input string name, input int lvl, input logic rdy, input logic vld,
                             input logic af, input logic ae, input int pk);
    checkValue({name, ".level"}, 32'(level_o), lvl);
    checkValue({name, ".ready"}, 32'(ready_o), 32'(rdy));
    checkValue({name, ".valid"}, 32'(valid_o), 32'(vld));
    checkValue({name, ".afull"}, 32'(almost_full_o), 32'(af));
    checkValue({name, ".aempty"}, 32'(almost_empty_o), 32'(ae));
    checkValue({name, ".peak"}, 32'(peak_o), pk);
  endtask

  // Called just after a rising edge; drives one cycle and returns #1 after the next edge.
  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic r, input logic f);
    bit acc_wr, acc_rd;
    valid_i = v;
    data_i  = d;
    ready_i = r;
    flush_i = f;
    acc_wr  = v && (model_level != 5);
    acc_rd  = r && (model_level != 0);
    @(posedge clk);
    if (f) begin
      expq.delete();
      model_level = 0;
    end else begin
      if (acc_wr) expq.push_back(d);
      model_level = model_level + int'(acc_wr) - int'(acc_rd);
    end
    #1;
  endtask

  // Monitor: a read will fire on the coming edge, so the head must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && !flush_i && valid_o && ready_i) begin
      if (expq.size() == 0) begin
        checks++;
        $display("[TB] FAIL scoreboard.unexpected_read: got data %0h, expected no read", data_o);
      end else begin
        checkValue("scoreboard.data", 32'(data_o), 32'(expq.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; flush_i = 1'b0; data_i = 8'h00; valid_i = 1'b0; ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 1, 0, 0, 1, 0);
    rst = 1'b0;

    // 1: fill with consumer stalled; sixth word must be held off
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, 8'(k), 1'b0, 1'b0);
      checkOutput($sformatf("fill%0d", k), (k < 5) ? k : 5, k < 5, 1'b1, k >= 4, k <= 1,
                  (k < 5) ? k : 5);
    end

    // 2: drain in order, peak holds
    for (int j = 1; j <= 5; j++) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
      checkOutput($sformatf("drain%0d", j), 5 - j, 1'b1, j < 5, (5 - j) >= 4, (5 - j) <= 1, 5);
    end

    // 3: prime two, then stream with both sides active; pointers wrap twice
    applyStimulus(1'b1, 8'h10, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 8'(8'h12 + i), 1'b1, 1'b0);
      checkValue($sformatf("stream%0d.level", i), 32'(level_o), 2);
    end
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("stream_drained", 0, 1, 0, 0, 1, 5);

    // 4: full with simultaneous read and write: only the read fires
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
    checkOutput("full", 5, 0, 1, 1, 0, 5);
    applyStimulus(1'b1, 8'h25, 1'b1, 1'b0);
    checkOutput("full_rdwr", 4, 1, 1, 1, 0, 5);
    applyStimulus(1'b1, 8'h26, 1'b0, 1'b0);
    checkOutput("refill", 5, 0, 1, 1, 0, 5);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("flush_full", 0, 1, 0, 0, 1, 0);

    // 5: flush at level 3 discards the concurrent handshake
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'h30 + i), 1'b0, 1'b0);
    checkOutput("level3", 3, 1, 1, 0, 0, 3);
    applyStimulus(1'b1, 8'h33, 1'b1, 1'b1);
    checkOutput("flush3", 0, 1, 0, 0, 1, 0);
    applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0);
    checkOutput("after_flush_wr", 1, 1, 1, 0, 1, 1);
    checkValue("after_flush_data", 32'(data_o), 32'h0AA);

    // 6: asynchronous reset mid-cycle at level 4
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hAB + i), 1'b0, 1'b0);
    valid_i = 1'b0;
    checkOutput("level4", 4, 1, 1, 1, 0, 4);
    #2 rst = 1'b1;
    #1 checkOutput("async_reset", 0, 1, 0, 0, 1, 0);
    expq.delete();
    model_level = 0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
    checkOutput("post_reset", 0, 1, 0, 0, 1, 1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkValue("scoreboard.empty", 32'(expq.size()), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fifo_sync_lvl.md
Name: fifo_sync_lvl

Overview:
Parametrised synchronous valid/ready FIFO, the next generation of the team's basic sync FIFO. Adds these features:
- Uses all DEPTH_P entries; DEPTH_P need not be a power of two.
- Exposes fill level with programmable almost-full/almost-empty thresholds.
- Synchronous flush.
- Peak-occupancy (high-water) monitor.

It sits between streaming producers and consumers in the datapath, and its monitor outputs feed status/debug registers.

Parameters:
- WIDTH_P, 8, data width in bits (>=1)
- DEPTH_P, 16, number of storage entries (>=2, any integer)
- AFULL_P, DEPTH_P-2, almost_full_o asserted when level >= AFULL_P (1..DEPTH_P)
- AEMPTY_P, 2, almost_empty_o asserted when level <= AEMPTY_P (0..DEPTH_P-1)
- PW_P, $clog2(DEPTH_P), pointer width (derived, do not override)
- CW_P, $clog2(DEPTH_P+1), level width (derived, do not override)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- flush_i  in  1  synchronous flush; empties FIFO and clears peak
- data_i  in  WIDTH_P  write data
- valid_i  in  1  write request
- ready_o  out  1  FIFO can accept; write occurs when valid_i & ready_o
- data_o  out  WIDTH_P  head-of-queue data (first-word-fall-through)
- valid_o  out  1  head data valid; read occurs when valid_o & ready_i
- ready_i  in  1  consumer accepts
- level_o  out  CW_P  current occupancy, 0..DEPTH_P
- almost_full_o  out  1  level_o >= AFULL_P
- almost_empty_o  out  1  level_o <= AEMPTY_P
- peak_o  out  CW_P  maximum level_o reached since reset/flush

Behaviour:
Reset (rst=1, asynchronous):
- wr_ptr=0, rd_ptr=0, level_o=0, peak_o=0
- ready_o=1, valid_o=0, almost_full_o=0, almost_empty_o=1
- Memory contents are not reset.
- data_o is don't-care while valid_o=0.

Handshakes:
- Write fires on wr = valid_i & ready_o. Read fires on rd = valid_o & ready_i.
- Both are registered on the same edge.
- data_i/valid_i may change freely while ready_o=0. No data is lost or duplicated.

Storage and pointers:
- Write: mem[wr_ptr] <= data_i on wr.
- data_o = mem[rd_ptr], combinational from the array; no extra output register.
- Pointers advance by 1 on their event and wrap explicitly from DEPTH_P-1 to 0. No reliance on binary overflow.

Level:
- next_level = level + wr - rd:
  - wr and rd together: unchanged.
  - wr only: +1.
  - rd only: -1.
- level_o, ready_o, valid_o and both almost flags are registered from next_level:
  - ready_o = (next_level != DEPTH_P)
  - valid_o = (next_level != 0)
  - almost_full_o = (next_level >= AFULL_P)
  - almost_empty_o = (next_level <= AEMPTY_P)
- All DEPTH_P entries are usable: ready_o drops only at level DEPTH_P.

Latency:
- A word written on edge N has valid_o=1 and data_o valid after edge N.
- Write-to-read latency is one cycle.
- A read on edge N frees space: ready_o=1 after edge N.

Boundaries:
- Full (level=DEPTH_P): ready_o=0, so writes are ignored. A read that cycle gives level DEPTH_P-1 and ready_o=1 next cycle.
- Empty: valid_o=0, so ready_i is ignored. A write that cycle gives valid_o=1 next cycle.
- Simultaneous rd and wr at any level in 1..DEPTH_P-1: level is unchanged, and both pointers advance with wrap.

Flush:
- flush_i=1 at an edge forces both pointers to 0, level to 0 and peak to 0.
- Flags take reset values on that same edge.
- Any wr/rd in the flush cycle is discarded; flush has priority.
- flush_i held high keeps the FIFO empty. ready_o stays 1, so a producer may see writes accepted-and-discarded.

Peak:
- On each edge without flush: peak <= max(peak, next_level).
- peak_o is monotonic until flush/rst.

rst asserted mid-operation: all state returns to reset values immediately. Any in-flight handshake is lost.

Test Plan:
1. DEPTH_P=5, AFULL_P=4, AEMPTY_P=1, ready_i=0. Write 0x01..0x06 back-to-back:
   - 0x01..0x05 accepted; ready_o=0 after the 5th write edge; 0x06 held, not written.
   - level_o=5, almost_full_o=1 from level 4, peak_o=5.
2. From scenario 1, ready_i=1, valid_i=0:
   - data_o=0x01..0x05 in order, one per cycle.
   - valid_o=0 after the 5th read edge; level_o=0, almost_empty_o=1, peak_o stays 5.
3. DEPTH_P=5, continuous valid_i=ready_i=1 for 12 cycles with incrementing data after priming 2 words:
   - level_o constant 2.
   - Pointers wrap 4->0 at least twice.
   - Output sequence equals input sequence with no gaps.
4. Full FIFO (level 5) with simultaneous valid_i=1 and ready_i=1:
   - Read fires, write does not.
   - level_o=4 and ready_o=1 next cycle; next write accepted.
5. Level 3, peak 3: assert flush_i for one cycle with valid_i=ready_i=1:
   - Next cycle level_o=0, valid_o=0, ready_o=1, peak_o=0.
   - Then write 0xAA: data_o=0xAA, valid_o=1 one cycle later.
6. Level 4: assert rst asynchronously mid-cycle:
   - Outputs go to reset values before the next clk edge: valid_o=0, level_o=0, ready_o=1, peak_o=0.
